daq_dma_arbiter: RTL and testbench

Packet-atomic round-robin arbiter that merges up to N_SRC 64-bit event streams (one per DAQ DMA manager instance) onto the single DMA stream toward the host interface. A grant is held from the first word to the word flagged last, so events never interleave. Per-source packet counters and a grant-status output support monitoring. Configuration is a per-source enable mask.

---
 rtl/daq_dma_pkg.sv | 24 ++
 rtl/daq_skid_buf.sv | 61 ++++++
 rtl/daq_dma_arbiter.sv | 152 +++++++++++++++
 tb/tb_daq_dma_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daq_dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : daq_dma_pkg
// Description : Shared definitions for the DAQ DMA path: arbiter state
//               encodings, default stream width and the event header magic
//               word written by the DAQ DMA managers.
// Revision    : 1.0 - initial release
// ============================================================================
package daq_dma_pkg;

  // Arbiter states: waiting for a request, or holding a grant until last.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } arb_state_e;

  // Default stream word width shared by managers and arbiter.
  localparam int DAQ_DATA_W = 64;

  // First-word marker that every DMA manager places at the head of an event.
  localparam logic [31:0] DAQ_HDR_MAGIC = 32'hDA0E_5A17;

endpackage
`default_nettype wire

// File: rtl/daq_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : daq_skid_buf
// Description : Two-entry registered valid/ready buffer. Outputs come straight
//               from flops and in_ready depends only on local state, so there
//               is no combinational path from out_ready back to in_ready.
// Ports       : clk, reset_n            clock, async active-low reset
//               in_data/in_valid/in_ready     upstream handshake
//               out_data/out_valid/out_ready  downstream handshake
// Revision    : 1.0 - initial release
// ============================================================================
module daq_skid_buf #(
  parameter int WIDTH = 67
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_full;

  // Accept whenever the spare slot is empty; a word arriving while the main
  // register is stalled lands in the skid slot.
  assign in_ready  = !skid_full;
  assign out_data  = main_data;
  assign out_valid = main_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_full  <= 1'b0;
    end else if (out_ready || !main_valid) begin
      if (skid_full) begin
        // in_ready is low here, so no new word competes with the skid entry
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_full  <= 1'b0;
      end else begin
        main_valid <= in_valid;
        if (in_valid) begin
          main_data <= in_data;
        end
      end
    end else if (in_valid && !skid_full) begin
      skid_data <= in_data;
      skid_full <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/daq_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : daq_dma_arbiter
// Description : Packet-atomic round-robin merge of N_SRC event streams onto one
//               DMA stream. A grant is held from first word to last word; the
//               most recently served source gets lowest priority next.
// Ports       : clk, reset_n                 clock, async active-low reset
//               src_enable                   per-source enable (arbitration only)
//               src_data/valid/last/ready    per-source input streams
//               dma_data/valid/last/src_id   merged output stream (registered)
//               dma_ready                    downstream accept
//               busy, grant_id               grant status
//               clear_counts, pkt_count      saturating per-source packet counts
// Revision    : 1.0 - initial release
// ============================================================================
module daq_dma_arbiter
  import daq_dma_pkg::*;
#(
  parameter int N_SRC  = 4,
  parameter int DATA_W = DAQ_DATA_W,
  parameter int CNT_W  = 16,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_SRC-1:0]        src_enable,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC-1:0]        src_last,
  output logic [N_SRC-1:0]        src_ready,
  output logic [DATA_W-1:0]       dma_data,
  output logic                    dma_valid,
  output logic                    dma_last,
  output logic [ID_W-1:0]         dma_src_id,
  input  logic                    dma_ready,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id,
  input  logic                    clear_counts,
  output logic [N_SRC*CNT_W-1:0]  pkt_count
);

  localparam int BUF_W = DATA_W + 1 + ID_W;

  arb_state_e       state;
  arb_state_e       state_next;
  logic [N_SRC-1:0] req;
  logic             in_valid;
  logic             buf_in_ready;
  logic             hs;
  logic             hs_last;
  int               gsel;
  logic [BUF_W-1:0] buf_in;
  logic [BUF_W-1:0] buf_out;

  // First requesting source after 'last', wrapping modulo N_SRC. The loop
  // ends on 'last' itself so a lone requester can be re-granted.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_SRC-1:0] r,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(last) + i) % N_SRC;
      if (!found && r[idx]) begin
        sel   = ID_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign req     = src_valid & src_enable;
  assign gsel    = int'(grant_id);
  assign hs      = in_valid & buf_in_ready;
  assign hs_last = hs & src_last[grant_id];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (|req)   state_next = ST_STREAM;
      ST_STREAM: if (hs_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output logic: only the granted source sees ready, and only in ST_STREAM
  always_comb begin
    src_ready = '0;
    in_valid  = 1'b0;
    busy      = 1'b0;
    if (state == ST_STREAM) begin
      busy                = 1'b1;
      in_valid            = src_valid[grant_id];
      src_ready[grant_id] = buf_in_ready;
    end
  end

  // Grant moves only at arbitration; src_enable is ignored mid-packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= ID_W'(N_SRC - 1);
    end else if (state == ST_IDLE && |req) begin
      grant_id <= rr_pick(req, grant_id);
    end
  end

  assign buf_in = {src_data[gsel*DATA_W +: DATA_W], src_last[grant_id], grant_id};

  daq_skid_buf #(
    .WIDTH (BUF_W)
  ) u_out_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (buf_in),
    .in_valid  (in_valid),
    .in_ready  (buf_in_ready),
    .out_data  (buf_out),
    .out_valid (dma_valid),
    .out_ready (dma_ready)
  );

  assign {dma_data, dma_last, dma_src_id} = buf_out;

  // Per-source completed-packet counters; clear wins over a same-cycle count.
  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count <= '0;
      end else if (clear_counts) begin
        count <= '0;
      end else if (hs_last && grant_id == ID_W'(g) && count != '1) begin
        count <= count + CNT_W'(1);
      end
    end
    assign pkt_count[g*CNT_W +: CNT_W] = count;
  end

endmodule
`default_nettype wire

// File: tb/tb_daq_dma_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_daq_dma_arbiter
// Description : Self-checking bench for daq_dma_arbiter. Packets are queued
//               per source; the expected merged word order is pushed to a
//               scoreboard as stimulus is created and popped as the DMA
//               output hands words over. Counters use CNT_W=8 so saturation
//               is reachable in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_daq_dma_arbiter;

  localparam int N_SRC  = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 8;
  localparam int ID_W   = 2;
  localparam int WORD_W = ID_W + 1 + DATA_W;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } sw_t;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [N_SRC-1:0]        src_enable;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC-1:0]        src_last;
  logic [N_SRC-1:0]        src_ready;
  logic [DATA_W-1:0]       dma_data;
  logic                    dma_valid;
  logic                    dma_last;
  logic [ID_W-1:0]         dma_src_id;
  logic                    dma_ready;
  logic                    busy;
  logic [ID_W-1:0]         grant_id;
  logic                    clear_counts;
  logic [N_SRC*CNT_W-1:0]  pkt_count;

  sw_t               src_q [N_SRC][$];
  logic [WORD_W-1:0] exp_q[$];
  logic [N_SRC-1:0]  hs = '0;
  int                ready_mode = 0;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  daq_dma_arbiter #(
    .N_SRC  (N_SRC),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .ID_W   (ID_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_enable   (src_enable),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .dma_data     (dma_data),
    .dma_valid    (dma_valid),
    .dma_last     (dma_last),
    .dma_src_id   (dma_src_id),
    .dma_ready    (dma_ready),
    .busy         (busy),
    .grant_id     (grant_id),
    .clear_counts (clear_counts),
    .pkt_count    (pkt_count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_word(input int src, input int seq, input int idx);
    return {8'hA0 + 8'(src), 24'(seq), 32'(idx) ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input int i);
    return pkt_count[i*CNT_W +: CNT_W];
  endfunction

  // Queue a packet at a source and/or push its words to the scoreboard.
  task automatic send_pkt(input int src, input int nw, input int seq,
                          input bit to_src, input bit to_exp);
    for (int w = 0; w < nw; w++) begin
      sw_t s;
      s.data = mk_word(src, seq, w);
      s.last = (w == nw - 1);
      if (to_src) src_q[src].push_back(s);
      if (to_exp) exp_q.push_back({ID_W'(src), s.last, s.data});
    end
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // Source driver: pop on a handshake seen at the previous negedge, then
  // present the head of each queue.
  initial begin
    src_valid = '0;
    src_last  = '0;
    src_data  = '0;
    dma_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N_SRC; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          src_valid[i]                  = 1'b1;
          src_last[i]                   = src_q[i][0].last;
          src_data[i*DATA_W +: DATA_W]  = src_q[i][0].data;
        end else begin
          src_valid[i] = 1'b0;
          src_last[i]  = 1'b0;
        end
      end
      case (ready_mode)
        1:       dma_ready = ~dma_ready;
        2:       dma_ready = 1'b0;
        default: dma_ready = 1'b1;
      endcase
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic [WORD_W-1:0] prev_word;
    logic [WORD_W-1:0] cur;
    bit                prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      hs = src_valid & src_ready;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {dma_src_id, dma_last, dma_data};
        if (prev_stall) check("dma_hold", {dma_valid, cur}, {1'b1, prev_word});
        if (dma_valid && dma_ready) begin
          if (exp_q.size() == 0) check("dma_unexpected", dma_valid, 1'b0);
          else                   check("dma_word", cur, exp_q.pop_front());
        end
        prev_stall = dma_valid && !dma_ready;
        prev_word  = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    src_enable   = '1;
    clear_counts = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_dma_valid", dma_valid, 0);
    check("rst_dma_last",  dma_last, 0);
    check("rst_dma_data",  dma_data, 0);
    check("rst_dma_id",    dma_src_id, 0);
    check("rst_busy",      busy, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_grant_id",  grant_id, 3);
    check("rst_counts",    pkt_count, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single source, 3-word packet: latency and back-to-back words
    send_pkt(0, 3, 1, 1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) check("t2_busy", busy, 1);
    end while (!dma_valid && n < 20);
    check("t2_latency", n, 3);
    for (int k = 0; k < 3; k++) begin
      check("t2_consec_valid", dma_valid, 1);
      check("t2_last", dma_last, (k == 2));
      @(negedge clk);
    end
    wait_drain("t2_drain", 50);
    check("t2_grant", grant_id, 0);
    check("t2_cnt0", cnt_of(0), 1);

    // All sources, two 2-word packets each: order 1,2,3,0,1,2,3,0
    for (int r = 0; r < 2; r++)
      for (int j = 1; j <= N_SRC; j++)
        send_pkt(j % N_SRC, 2, 10 + r, 1, 1);
    wait_drain("t3_drain", 200);
    check("t3_cnt0", cnt_of(0), 3);
    check("t3_cnt1", cnt_of(1), 2);
    check("t3_cnt2", cnt_of(2), 2);
    check("t3_cnt3", cnt_of(3), 2);

    // Backpressure: dma_ready toggling during a 5-word packet
    ready_mode = 1;
    send_pkt(2, 5, 20, 1, 1);
    wait_drain("t4_drain", 100);
    ready_mode = 0;
    check("t4_cnt2", cnt_of(2), 3);

    // Enable mask 1010: sources 0 and 2 wait, 1 and 3 alternate (3 first)
    src_enable = 4'b1010;
    send_pkt(0, 2, 30, 1, 0);
    send_pkt(2, 2, 31, 1, 0);
    send_pkt(3, 2, 32, 1, 1);
    send_pkt(1, 2, 33, 1, 1);
    send_pkt(3, 2, 34, 1, 1);
    send_pkt(1, 2, 35, 1, 1);
    wait_drain("t5_drain", 200);
    repeat (3) @(negedge clk);
    check("t5_idle_busy", busy, 0);
    check("t5_cnt1", cnt_of(1), 4);
    check("t5_cnt3", cnt_of(3), 4);

    // Disable source 1 mid-packet: packet completes, then only source 3
    send_pkt(1, 4, 40, 1, 1);
    send_pkt(1, 2, 41, 1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(src_valid[1] && src_ready[1]) && n < 20);
    check("t6_src1_start", src_valid[1] & src_ready[1], 1);
    src_enable = 4'b1000;
    send_pkt(3, 2, 42, 1, 1);
    send_pkt(3, 2, 43, 1, 1);
    wait_drain("t6_drain", 100);
    check("t6_cnt1", cnt_of(1), 5);
    check("t6_cnt3", cnt_of(3), 6);

    // Re-enable all: waiting sources drain in order 0,1,2
    src_enable = '1;
    send_pkt(0, 2, 30, 0, 1);
    send_pkt(1, 2, 41, 0, 1);
    send_pkt(2, 2, 31, 0, 1);
    wait_drain("t7_drain", 100);
    check("t7_cnt0", cnt_of(0), 4);
    check("t7_cnt1", cnt_of(1), 6);
    check("t7_cnt2", cnt_of(2), 4);
    check("t7_cnt3", cnt_of(3), 6);

    // clear_counts in the completion cycle of source 2
    send_pkt(2, 1, 50, 1, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(src_valid[2] && src_ready[2] && src_last[2]) && n < 20);
    clear_counts = 1'b1;
    @(negedge clk);
    clear_counts = 1'b0;
    check("t8_cnt2_cleared", cnt_of(2), 0);
    check("t8_all_cleared", pkt_count, 0);
    wait_drain("t8_drain", 50);

    // Saturation at 2^CNT_W-1
    for (int p = 0; p < 255; p++) send_pkt(1, 1, 100 + p, 1, 1);
    wait_drain("t9_drain", 2000);
    check("t9_cnt1_max", cnt_of(1), 255);
    send_pkt(1, 1, 400, 1, 1);
    wait_drain("t9_drain2", 50);
    check("t9_cnt1_sat", cnt_of(1), 255);
    check("t9_cnt0", cnt_of(0), 0);

    // Reset mid-packet, then source 0 must win the first arbitration
    ready_mode = 2;
    send_pkt(3, 6, 60, 1, 0);
    repeat (6) @(negedge clk);
    check("t10_pre_busy", busy, 1);
    check("t10_pre_valid", dma_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t10_rst_valid", dma_valid, 0);
    check("t10_rst_ready", src_ready, 0);
    check("t10_rst_busy", busy, 0);
    for (int i = 0; i < N_SRC; i++) src_q[i].delete();
    exp_q.delete();
    ready_mode = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("t10_grant_rst", grant_id, 3);
    send_pkt(0, 2, 71, 1, 1);
    send_pkt(3, 2, 70, 1, 1);
    wait_drain("t10_drain", 100);
    check("t10_grant_end", grant_id, 3);
    check("t10_cnt0", cnt_of(0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
